trigger_detect: RTL and testbench
=================================

TRIGGER_DETECT -- requirements
Module: trigger_detect

Interface
REQ-001 The block SHALL use clock sys_clk and reset sys_rst_n, asynchronous, active-low.
REQ-002 Parameters SHALL be: DATA_W, default 8, ADC sample width; CNT_W, default 16, holdoff/timeout counter width.
REQ-003 Ports SHALL be, clock and reset first:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  async active-low reset
- adc_valid  in  1  adc_data qualifier, one sample per asserted cycle
- adc_data  in  DATA_W  unsigned ADC sample
- trig_level  in  DATA_W  unsigned threshold
- trig_hyst  in  DATA_W  unsigned hysteresis band
- trig_edge  in  1  0 = rising, 1 = falling
- trig_mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal
- holdoff  in  CNT_W  post-trigger dead time, sys_clk cycles
- auto_timeout  in  CNT_W  auto-mode force interval, sys_clk cycles
- arm  in  1  single-cycle arm request
- disarm  in  1  single-cycle abort request
- en_pulse  out  1  single-cycle trigger pulse to the downstream gate shaper
- trig_forced  out  1  high with en_pulse when the trigger was auto-forced
- trig_armed  out  1  high in PRE and READY

Function
REQ-004 The FSM SHALL have states IDLE, PRE, READY, HOLD.
REQ-005 IDLE -> PRE on arm; all other inputs SHALL be ignored in IDLE.
REQ-006 On leaving IDLE and on every HOLD -> PRE, trig_level, trig_hyst, trig_edge, trig_mode, holdoff and auto_timeout SHALL be captured into shadow registers; all decisions SHALL use the shadow values only.
REQ-007 Lower threshold lo = level - hyst, saturating at 0; upper threshold hi = level + hyst, saturating at 2^DATA_W - 1; arithmetic SHALL be DATA_W+1 bits wide before saturation.
REQ-008 PRE -> READY on an adc_valid sample with adc_data < lo (rising) or adc_data > hi (falling).
REQ-009 READY -> HOLD on an adc_valid sample with adc_data >= level (rising) or adc_data <= level (falling); en_pulse SHALL be 1 in exactly the following cycle (latency 1 from the qualifying sample).
REQ-010 A sample satisfying the fire condition while in PRE SHALL NOT fire.
REQ-011 HOLD SHALL last holdoff cycles counted from the cycle en_pulse is high; holdoff = 0 SHALL leave HOLD in the next cycle.
REQ-012 HOLD exit: single mode -> IDLE; auto/normal -> PRE.
REQ-013 Auto mode: a counter SHALL start at 0 on entry to PRE and count every cycle in PRE/READY; on reaching auto_timeout without a fire, the FSM SHALL enter HOLD, and en_pulse and trig_forced SHALL both be 1 in the next cycle.
REQ-014 auto_timeout = 0 SHALL disable forcing.
REQ-015 If the fire condition and timeout occur in the same cycle, the real trigger SHALL win (trig_forced = 0).
REQ-016 disarm SHALL force IDLE in the next cycle from any state, cancel a pending en_pulse, and win over a simultaneous arm.
REQ-017 en_pulse SHALL never be high in two consecutive cycles.
REQ-018 adc_valid = 0 cycles SHALL not affect state except the holdoff and timeout counters.

Reset
REQ-019 During reset: state IDLE, all counters 0, shadow registers 0, en_pulse = 0, trig_forced = 0, trig_armed = 0.
REQ-020 Reset deassertion mid-operation SHALL require a new arm before any en_pulse.

Verification
REQ-021 Normal, rising, level 128, hyst 8: samples 100, 130 after arm -> READY at 100, en_pulse one cycle after 130, trig_forced 0.
REQ-022 Noise rejection: samples 125, 130, 123, 140 (lo 120) -> no en_pulse; 119 then 128 -> one en_pulse.
REQ-023 Holdoff 10, repeated qualifying edges -> no second en_pulse within 10 cycles; next fires only after fresh PRE -> READY.
REQ-024 Auto mode, auto_timeout 50, flat input 128 -> en_pulse with trig_forced every 50 + holdoff + 1 cycles.
REQ-025 Single mode, falling, level 10, hyst 20 (hi 30) -> one trigger on 40 then 5; later edges ignored until arm.
REQ-026 disarm in the same cycle as a qualifying sample -> no en_pulse, IDLE; async reset while in HOLD -> all outputs 0 immediately.

Source files
------------

// File: rtl/trigger_detect.sv
// Oscilloscope-style trigger: hysteresis-qualified edge detector with holdoff,
// auto-mode forcing and single-shot operation, driving a one-cycle en_pulse.
module trigger_detect #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [DATA_W-1:0] trig_level,
   input  logic [DATA_W-1:0] trig_hyst,
   input  logic              trig_edge,
   input  logic [1:0]        trig_mode,
   input  logic [CNT_W-1:0]  holdoff,
   input  logic [CNT_W-1:0]  auto_timeout,
   input  logic              arm,
   input  logic              disarm,
   output logic              en_pulse,
   output logic              trig_forced,
   output logic              trig_armed
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRE   = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam logic [1:0] MODE_AUTO   = 2'b00;
   localparam logic [1:0] MODE_SINGLE = 2'b10;

   logic [1:0]        state_reg, state_next;
   logic [DATA_W-1:0] level_reg, hyst_reg;
   logic              edge_reg;
   logic [1:0]        mode_reg;
   logic [CNT_W-1:0]  holdoff_reg, timeout_reg;
   logic [CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;
   logic [CNT_W-1:0]  to_cnt_reg, to_cnt_next;
   logic              en_pulse_reg, en_pulse_next;
   logic              forced_reg, forced_next;
   logic              capture;

   logic [DATA_W:0]   sum_ext, diff_ext;
   logic [DATA_W-1:0] thr_lo, thr_hi;
   logic              arm_cond, fire_cond, fire, timeout_hit, hold_done, in_pre_ready;

   // One extra bit exposes borrow/carry so the band edges clamp instead of wrapping.
   assign sum_ext  = {1'b0, level_reg} + {1'b0, hyst_reg};
   assign diff_ext = {1'b0, level_reg} - {1'b0, hyst_reg};
   assign thr_lo   = diff_ext[DATA_W] ? '0 : diff_ext[DATA_W-1:0];
   assign thr_hi   = sum_ext[DATA_W]  ? '1 : sum_ext[DATA_W-1:0];

   assign in_pre_ready = (state_reg == ST_PRE) || (state_reg == ST_READY);
   assign arm_cond  = adc_valid && (edge_reg ? (adc_data > thr_hi) : (adc_data < thr_lo));
   assign fire_cond = adc_valid && (edge_reg ? (adc_data <= level_reg) : (adc_data >= level_reg));
   assign fire      = (state_reg == ST_READY) && fire_cond;
   assign timeout_hit = in_pre_ready && (mode_reg == MODE_AUTO) &&
                        (timeout_reg != '0) && (to_cnt_reg == timeout_reg);
   assign hold_done = hold_cnt_reg >= holdoff_reg;

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      to_cnt_next   = to_cnt_reg;
      en_pulse_next = 1'b0;
      forced_next   = 1'b0;
      capture       = 1'b0;
      if (disarm) begin
         state_next    = ST_IDLE;
         hold_cnt_next = '0;
         to_cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (arm) begin
                  state_next  = ST_PRE;
                  capture     = 1'b1;
                  to_cnt_next = '0;
               end
            end
            ST_PRE, ST_READY: begin
               to_cnt_next = (to_cnt_reg == '1) ? to_cnt_reg : to_cnt_reg + CNT_W'(1);
               // A real edge beats a coincident timeout so forced is only reported when nothing fired.
               if (fire || timeout_hit) begin
                  state_next    = ST_HOLD;
                  en_pulse_next = 1'b1;
                  forced_next   = !fire;
                  hold_cnt_next = CNT_W'(1);
               end else if ((state_reg == ST_PRE) && arm_cond) begin
                  state_next = ST_READY;
               end
            end
            default: begin
               if (hold_done) begin
                  hold_cnt_next = '0;
                  to_cnt_next   = '0;
                  if (mode_reg == MODE_SINGLE) begin
                     state_next = ST_IDLE;
                  end else begin
                     state_next = ST_PRE;
                     capture    = 1'b1;
                  end
               end else begin
                  hold_cnt_next = hold_cnt_reg + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg    <= ST_IDLE;
         hold_cnt_reg <= '0;
         to_cnt_reg   <= '0;
         en_pulse_reg <= 1'b0;
         forced_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         to_cnt_reg   <= to_cnt_next;
         en_pulse_reg <= en_pulse_next;
         forced_reg   <= forced_next;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         level_reg   <= '0;
         hyst_reg    <= '0;
         edge_reg    <= 1'b0;
         mode_reg    <= '0;
         holdoff_reg <= '0;
         timeout_reg <= '0;
      end else if (capture) begin
         level_reg   <= trig_level;
         hyst_reg    <= trig_hyst;
         edge_reg    <= trig_edge;
         mode_reg    <= trig_mode;
         holdoff_reg <= holdoff;
         timeout_reg <= auto_timeout;
      end
   end

   assign en_pulse    = en_pulse_reg;
   assign trig_forced = forced_reg;
   assign trig_armed  = in_pre_ready;

endmodule

// File: tb/tb_trigger_detect.sv
// Bench for trigger_detect: directed vector table, corner-case sequences and
// randomized traffic checked against an event/deadline-based reference model.
module tb_trigger_detect;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;
   localparam int MAXV   = (1 << DATA_W) - 1;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic              adc_valid;
   logic [DATA_W-1:0] adc_data, trig_level, trig_hyst;
   logic              trig_edge;
   logic [1:0]        trig_mode;
   logic [CNT_W-1:0]  holdoff, auto_timeout;
   logic              arm, disarm;
   logic              en_pulse, trig_forced, trig_armed;

   trigger_detect #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
      .trig_level(trig_level), .trig_hyst(trig_hyst), .trig_edge(trig_edge), .trig_mode(trig_mode),
      .holdoff(holdoff), .auto_timeout(auto_timeout), .arm(arm), .disarm(disarm),
      .en_pulse(en_pulse), .trig_forced(trig_forced), .trig_armed(trig_armed)
   );

   always #5 sys_clk = ~sys_clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: phase plus absolute-cycle deadlines for holdoff and auto timeout.
   typedef enum int {M_IDLE, M_PRE, M_READY, M_HOLD} mphase_t;
   mphase_t m_phase;
   int m_cyc, m_pre_start, m_hold_end;
   int s_level, s_hyst, s_edge, s_mode, s_holdoff, s_timeout;
   bit m_pulse, m_forced;

   function void model_reset();
      m_phase = M_IDLE; m_pulse = 0; m_forced = 0;
      s_level = 0; s_hyst = 0; s_edge = 0; s_mode = 0; s_holdoff = 0; s_timeout = 0;
   endfunction

   function void model_capture();
      s_level = int'(trig_level); s_hyst = int'(trig_hyst); s_edge = int'(trig_edge);
      s_mode = int'(trig_mode); s_holdoff = int'(holdoff); s_timeout = int'(auto_timeout);
      m_pre_start = m_cyc + 1;
   endfunction

   function void model_step();
      int lo, hi, d;
      bit fire_ok, timed;
      lo = s_level - s_hyst; if (lo < 0) lo = 0;
      hi = s_level + s_hyst; if (hi > MAXV) hi = MAXV;
      d = int'(adc_data);
      m_pulse = 0; m_forced = 0;
      if (disarm) m_phase = M_IDLE;
      else case (m_phase)
         M_IDLE: if (arm) begin model_capture(); m_phase = M_PRE; end
         M_PRE, M_READY: begin
            fire_ok = (m_phase == M_READY) && adc_valid && (s_edge != 0 ? d <= s_level : d >= s_level);
            timed = (s_mode == 0) && (s_timeout != 0) && ((m_cyc - m_pre_start) == s_timeout);
            if (fire_ok || timed) begin
               m_pulse = 1; m_forced = !fire_ok; m_phase = M_HOLD;
               m_hold_end = m_cyc + (s_holdoff > 1 ? s_holdoff : 1);
            end else if (m_phase == M_PRE && adc_valid && (s_edge != 0 ? d > hi : d < lo))
               m_phase = M_READY;
         end
         M_HOLD: if (m_cyc >= m_hold_end) begin
            if (s_mode == 2) m_phase = M_IDLE;
            else begin model_capture(); m_phase = M_PRE; end
         end
         default: m_phase = M_IDLE;
      endcase
      m_cyc++;
   endfunction

   task automatic check(string name, logic ep, logic ef, logic ea);
      vec_cnt++;
      if ({en_pulse, trig_forced, trig_armed} !== {ep, ef, ea}) begin
         err_cnt++;
         $display("FAIL %s @%0t: en_pulse/trig_forced/trig_armed = %b%b%b, expected %b%b%b",
                  name, $time, en_pulse, trig_forced, trig_armed, ep, ef, ea);
      end
   endtask

   task automatic check_model(string name);
      check(name, m_pulse, m_forced, (m_phase == M_PRE) || (m_phase == M_READY));
   endtask

   task automatic check_bit(string name, logic act, logic exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_step();
      #1;
   endtask

   task automatic drive(logic v, int d, logic a, logic da);
      adc_valid = v; adc_data = DATA_W'(d); arm = a; disarm = da;
   endtask

   task automatic set_cfg(int lvl, int hy, logic edg, logic [1:0] md, int ho, int to);
      trig_level = DATA_W'(lvl); trig_hyst = DATA_W'(hy); trig_edge = edg;
      trig_mode = md; holdoff = CNT_W'(ho); auto_timeout = CNT_W'(to);
   endtask

   task automatic go_idle();
      drive(0, 0, 0, 1); tick(); check_model("disarm_to_idle");
      drive(0, 0, 0, 0);
   endtask

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       arm;
      logic       disarm;
      logic       ep;
      logic       ef;
      logic       ea;
   } vec_t;

   vec_t tbl[21];
   int pulses, last_pulse;

   initial begin
      // Normal rising, level 128 hyst 8 (lo 120), holdoff 3: HOLD spans three cycles.
      tbl[0]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 8'd130, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 8'd125, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 8'd130, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 8'd123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 8'd140, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 8'd119, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 8'd128, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 8'd130, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      m_cyc = 0; m_pre_start = 0; m_hold_end = 0;
      model_reset();
      sys_rst_n = 1'b0;
      drive(0, 0, 0, 0);
      set_cfg(0, 0, 0, 2'b01, 0, 0);
      repeat (2) @(posedge sys_clk);
      #1;
      check("reset_state", 1'b0, 1'b0, 1'b0);
      sys_rst_n = 1'b1;

      set_cfg(128, 8, 0, 2'b01, 3, 0);
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].valid, int'(tbl[i].data), tbl[i].arm, tbl[i].disarm);
         tick();
         $display("vec %0d: valid=%b data=%0d arm=%b disarm=%b -> en_pulse=%b forced=%b armed=%b",
                  i, tbl[i].valid, tbl[i].data, tbl[i].arm, tbl[i].disarm, en_pulse, trig_forced, trig_armed);
         check($sformatf("table_%0d", i), tbl[i].ep, tbl[i].ef, tbl[i].ea);
      end
      go_idle();

      // Holdoff 10: alternating edges during HOLD must be ignored, then a fresh PRE->READY is needed.
      set_cfg(128, 8, 0, 2'b01, 10, 0);
      drive(0, 0, 1, 0); tick(); check_model("ho_arm");
      drive(1, 100, 0, 0); tick(); check_model("ho_ready");
      drive(1, 130, 0, 0); tick(); check("ho_fire", 1'b1, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, (i % 2 == 0) ? 100 : 130, 0, 0); tick(); check_model("ho_window");
         if (en_pulse) pulses++;
      end
      check_int("ho_no_repeat", pulses, 0);
      drive(1, 130, 0, 0); tick(); check("ho_pre_no_fire", 1'b0, 1'b0, 1'b1);
      drive(1, 100, 0, 0); tick(); check_model("ho_rearm");
      drive(1, 130, 0, 0); tick(); check("ho_refire", 1'b1, 1'b0, 1'b0);
      go_idle();

      // Fire and timeout in the same cycle: the real trigger wins.
      set_cfg(128, 8, 0, 2'b00, 2, 3);
      drive(0, 0, 1, 0); tick();
      drive(1, 100, 0, 0); tick();
      drive(0, 0, 0, 0); tick(); tick();
      drive(1, 130, 0, 0); tick(); check("tie_real_wins", 1'b1, 1'b0, 1'b0);
      go_idle();

      // Auto mode, flat input: forced pulses every timeout + holdoff + 1 cycles.
      set_cfg(128, 8, 0, 2'b00, 5, 50);
      drive(0, 0, 1, 0); tick(); check_model("auto_arm");
      pulses = 0; last_pulse = -1;
      for (int i = 1; i <= 200; i++) begin
         drive(1, 128, 0, 0); tick(); check_model("auto_run");
         if (en_pulse) begin
            $display("auto trigger at cycle %0d forced=%b", i, trig_forced);
            check_bit("auto_forced", trig_forced, 1'b1);
            if (last_pulse >= 0) check_int("auto_period", i - last_pulse, 50 + 5 + 1);
            last_pulse = i; pulses++;
         end
      end
      check_int("auto_count", pulses, 3);
      go_idle();

      // Single mode, falling, level 10 hyst 20: one trigger then back to IDLE.
      set_cfg(10, 20, 1, 2'b10, 2, 0);
      drive(0, 0, 1, 0); tick(); check_model("single_arm");
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1, (i % 2 == 0) ? 40 : 5, 0, 0); tick(); check_model("single_run");
         if (en_pulse) pulses++;
      end
      check_int("single_once", pulses, 1);
      check_bit("single_idle", trig_armed, 1'b0);

      // Asynchronous reset while in HOLD clears outputs at once; no pulse without a new arm.
      set_cfg(128, 8, 0, 2'b01, 10, 0);
      drive(0, 0, 1, 0); tick();
      drive(1, 100, 0, 0); tick();
      drive(1, 130, 0, 0); tick(); check_model("rst_pre_fire");
      sys_rst_n = 1'b0;
      #1;
      check("rst_in_hold", 1'b0, 1'b0, 1'b0);
      model_reset();
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1, (i % 2 == 0) ? 100 : 130, 0, 0); tick(); check_model("post_rst_no_arm");
      end

      // Randomized traffic with live config changes exercising the shadow registers.
      for (int i = 0; i < 1500; i++) begin
         set_cfg($urandom_range(0, MAXV), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 8), $urandom_range(0, 30));
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, MAXV),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
         tick(); check_model("random");
         if (en_pulse) $display("random trigger at step %0d forced=%b", i, trig_forced);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
